// File: rtl/delta_sigma_mc_modulator.sv
// Time-multiplexed multi-channel error-feedback delta-sigma modulator.
// One sequencer and one accumulator adder serve all channels; order 0..3 and TPDF dither are selected per frame.
module delta_sigma_mc_modulator #(
  parameter int IN_BITS     = 16,
  parameter int FRAC_BITS   = 11,
  parameter int OUT_BITS    = 6,
  parameter int NUM_CH      = 2,
  parameter int MAX_ORDER   = 3,
  parameter int DITHER_BITS = 8,
  parameter int LFSR_BITS   = 22,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic [NUM_CH*IN_BITS-1:0]  u,
  input  logic [1:0]                 order,
  input  logic                       dither_en,
  output logic                       busy,
  output logic                       y_valid,
  output logic [OUT_BITS-1:0]        y,
  output logic [CH_W-1:0]            y_ch,
  output logic                       frame_done,
  output logic                       overrun
);

  localparam int ACC_W = IN_BITS + 4;
  localparam int ERR_W = FRAC_BITS + 2;
  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(2**(FRAC_BITS-1));
  localparam logic signed [ACC_W-1:0] Y_MAX   = ACC_W'(2**OUT_BITS - 1);
  localparam logic signed [ACC_W-1:0] ERR_MAX = ACC_W'(2**(ERR_W-1) - 1);
  localparam logic signed [ACC_W-1:0] ERR_MIN = ~ERR_MAX;
  localparam logic [1:0]              ORD_MAX = 2'(MAX_ORDER);

  typedef enum logic [1:0] {IDLE, LOAD, TAP, QUANT} state_t;

  state_t                   state_reg;
  logic [CH_W-1:0]          ch_reg;
  logic [1:0]               tap_reg;
  logic [1:0]               ord_reg;
  logic                     dith_reg;
  logic [IN_BITS-1:0]       u_lat_reg [NUM_CH];
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ERR_W-1:0]  hist_reg [NUM_CH][3];
  logic [LFSR_BITS-1:0]     lfsr_reg;

  logic [IN_BITS-1:0]       u_in [NUM_CH];
  logic signed [DITHER_BITS:0] dither;
  logic signed [ERR_W-1:0]  e_sel;
  logic signed [ACC_W-1:0]  load_next, e_ext, tap_mag, acc_next;
  logic signed [ACC_W-1:0]  rounded, q, y_shift, err_full;
  logic                     tap_sub;
  logic [OUT_BITS-1:0]      y_next;
  logic signed [ERR_W-1:0]  err_next;
  logic [1:0]               ord_in;
  logic                     last_ch;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign u_in[gi] = u[gi*IN_BITS +: IN_BITS];
    end
  endgenerate

  always_comb begin
    // Difference of two uniform terms gives a triangular PDF centred on zero.
    dither = $signed({1'b0, lfsr_reg[DITHER_BITS-1:0]})
           - $signed({1'b0, lfsr_reg[2*DITHER_BITS-1:DITHER_BITS]});
    load_next = $signed({{(ACC_W-IN_BITS){1'b0}}, u_lat_reg[ch_reg]});
    if (dith_reg)
      load_next = load_next + {{(ACC_W-DITHER_BITS-1){dither[DITHER_BITS]}}, dither};

    e_sel   = hist_reg[ch_reg][tap_reg];
    e_ext   = {{(ACC_W-ERR_W){e_sel[ERR_W-1]}}, e_sel};
    tap_mag = e_ext;
    tap_sub = 1'b0;
    case ({ord_reg, tap_reg})
      {2'd2, 2'd0}: tap_mag = e_ext <<< 1;
      {2'd2, 2'd1}: tap_sub = 1'b1;
      {2'd3, 2'd0}: tap_mag = (e_ext <<< 1) + e_ext;
      {2'd3, 2'd1}: begin
        tap_mag = (e_ext <<< 1) + e_ext;
        tap_sub = 1'b1;
      end
      default: ;
    endcase
    acc_next = tap_sub ? (acc_reg - tap_mag) : (acc_reg + tap_mag);

    rounded = acc_reg + HALF;
    q       = rounded >>> FRAC_BITS;
    if (q[ACC_W-1])
      y_next = '0;
    else if (q > Y_MAX)
      y_next = '1;
    else
      y_next = q[OUT_BITS-1:0];

    y_shift  = $signed({{(ACC_W-OUT_BITS-FRAC_BITS){1'b0}}, y_next, {FRAC_BITS{1'b0}}});
    err_full = acc_reg - y_shift;
    if (err_full > ERR_MAX)
      err_next = ERR_MAX[ERR_W-1:0];
    else if (err_full < ERR_MIN)
      err_next = ERR_MIN[ERR_W-1:0];
    else
      err_next = err_full[ERR_W-1:0];

    ord_in  = (order > ORD_MAX) ? ORD_MAX : order;
    last_ch = (ch_reg == CH_W'(NUM_CH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      ch_reg     <= '0;
      tap_reg    <= '0;
      ord_reg    <= '0;
      dith_reg   <= 1'b0;
      acc_reg    <= '0;
      lfsr_reg   <= '1;
      busy       <= 1'b0;
      y_valid    <= 1'b0;
      y          <= '0;
      y_ch       <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        u_lat_reg[c] <= '0;
        for (int k = 0; k < 3; k++) hist_reg[c][k] <= '0;
      end
    end else begin
      y_valid    <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start && busy) overrun <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (frame_start && !busy) begin
            for (int c = 0; c < NUM_CH; c++) u_lat_reg[c] <= u_in[c];
            ord_reg   <= ord_in;
            dith_reg  <= dither_en;
            ch_reg    <= '0;
            busy      <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          acc_reg <= load_next;
          if (dith_reg)
            lfsr_reg <= {lfsr_reg[LFSR_BITS-2:0], lfsr_reg[LFSR_BITS-1] ^ lfsr_reg[LFSR_BITS-2]};
          tap_reg   <= '0;
          state_reg <= (ord_reg == 2'd0) ? QUANT : TAP;
        end
        TAP: begin
          acc_reg <= acc_next;
          if (tap_reg == ord_reg - 2'd1)
            state_reg <= QUANT;
          else
            tap_reg <= tap_reg + 2'd1;
        end
        QUANT: begin
          y       <= y_next;
          y_ch    <= ch_reg;
          y_valid <= 1'b1;
          hist_reg[ch_reg][2] <= hist_reg[ch_reg][1];
          hist_reg[ch_reg][1] <= hist_reg[ch_reg][0];
          hist_reg[ch_reg][0] <= err_next;
          if (last_ch) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            ch_reg    <= ch_reg + CH_W'(1);
            state_reg <= LOAD;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delta_sigma_mc_modulator.sv
// Scoreboard bench for delta_sigma_mc_modulator: an integer reference model predicts every output sample
// and its arrival cycle at frame accept; a negedge monitor pops and compares as y_valid strobes appear.
module tb_delta_sigma_mc_modulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [31:0] u;
  logic [1:0]  order;
  logic        dither_en;
  logic        busy, y_valid, frame_done, overrun;
  logic [5:0]  y;
  logic        y_ch;

  delta_sigma_mc_modulator dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .u(u), .order(order),
    .dither_en(dither_en), .busy(busy), .y_valid(y_valid), .y(y), .y_ch(y_ch),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] y;
    logic       ch;
    logic       done;
    longint     cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  longint      cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          sum_y[2];
  int          min_y;
  int          hist_m[2][3];
  logic [21:0] lfsr_m;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: integer arithmetic, explicit error-feedback filter per channel.
  function automatic logic [5:0] model_step(input int c, input int uval, input int ord, input bit den);
    int acc, d, q, yv, e;
    d = 0;
    if (den) begin
      d = int'(lfsr_m[7:0]) - int'(lfsr_m[15:8]);
      lfsr_m = {lfsr_m[20:0], lfsr_m[21] ^ lfsr_m[20]};
    end
    acc = uval + d;
    case (ord)
      1: acc = acc + hist_m[c][0];
      2: acc = acc + 2*hist_m[c][0] - hist_m[c][1];
      3: acc = acc + 3*hist_m[c][0] - 3*hist_m[c][1] + hist_m[c][2];
      default: ;
    endcase
    q = (acc + 1024) >>> 11;
    yv = (q < 0) ? 0 : ((q > 63) ? 63 : q);
    e = acc - yv*2048;
    if (e > 4095) e = 4095;
    if (e < -4096) e = -4096;
    hist_m[c][2] = hist_m[c][1];
    hist_m[c][1] = hist_m[c][0];
    hist_m[c][0] = e;
    return 6'(yv);
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0 && y_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_y_valid: y=%0d ch=%0d at cycle %0d, nothing pending", y, y_ch, cyc);
      end else begin
        mon_e = sb.pop_front();
        n_checks++;
        if (y !== mon_e.y) begin
          n_fail++;
          $display("FAIL y_value: ch=%0d got %0d expected %0d", mon_e.ch, y, mon_e.y);
        end
        n_checks++;
        if (y_ch !== mon_e.ch) begin
          n_fail++;
          $display("FAIL y_ch: got %0d expected %0d", y_ch, mon_e.ch);
        end
        n_checks++;
        if (frame_done !== mon_e.done) begin
          n_fail++;
          $display("FAIL frame_done: ch=%0d got %0b expected %0b", mon_e.ch, frame_done, mon_e.done);
        end
        n_checks++;
        if (cyc !== mon_e.cyc) begin
          n_fail++;
          $display("FAIL y_valid_timing: ch=%0d at cycle %0d expected %0d", mon_e.ch, cyc, mon_e.cyc);
        end
        $display("sample ch=%0d y=%0d cycle=%0d", y_ch, y, cyc);
        sum_y[y_ch] += int'(y);
        if (int'(y) < min_y) min_y = int'(y);
      end
    end
  end

  task automatic clear_stats();
    sum_y[0] = 0;
    sum_y[1] = 0;
    min_y = 1000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    lfsr_m = '1;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 3; k++) hist_m[c][k] = 0;
  endtask

  // Drives one frame; returns one cycle after the accept edge so calls chain back to back.
  task automatic run_frame(input int u0, input int u1, input int ord, input bit den);
    int waited;
    longint t0;
    exp_t ev;
    waited = 0;
    while (busy !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (busy !== 1'b0) begin
      n_checks++; n_fail++;
      $display("FAIL busy_wait: busy=%b still set after %0d cycles, expected 0", busy, waited);
      return;
    end
    u = {u1[15:0], u0[15:0]};
    order = 2'(ord);
    dither_en = den;
    frame_start = 1'b1;
    t0 = cyc + 1;
    for (int c = 0; c < 2; c++) begin
      ev.y = model_step(c, (c == 0) ? u0 : u1, ord, den);
      ev.ch = c[0];
      ev.done = (c == 1);
      ev.cyc = t0 + longint'((c + 1) * (ord + 2));
      sb.push_back(ev);
    end
    $display("frame u0=0x%04h u1=0x%04h order=%0d dither=%0b accept_cycle=%0d", u0[15:0], u1[15:0], ord, den, t0);
    @(negedge clk);
    frame_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_accept: got %b expected 1", busy);
    end
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: %0d samples outstanding, busy=%b, expected 0 and 0", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if (y !== 6'd0) begin n_fail++; $display("FAIL reset_y: got %0d expected 0", y); end
    n_checks++; if (y_ch !== 1'b0) begin n_fail++; $display("FAIL reset_y_ch: got %0d expected 0", y_ch); end
  endtask

  task automatic test_order0();
    do_reset();
    clear_stats();
    for (int i = 0; i < 8; i++) run_frame(16'h2C00, 16'h2C00, 0, 1'b0);
    wait_idle();
    n_checks++;
    if (sum_y[0] != 48) begin n_fail++; $display("FAIL order0_sum: got %0d expected 48", sum_y[0]); end
  endtask

  task automatic test_order1();
    do_reset();
    clear_stats();
    for (int i = 0; i < 64; i++) run_frame(16'h2C00, 16'h2C00, 1, 1'b0);
    wait_idle();
    n_checks++;
    if (sum_y[0] != 352) begin n_fail++; $display("FAIL order1_mean: sum %0d expected 352", sum_y[0]); end
  endtask

  task automatic test_two_channel();
    int s0;
    do_reset();
    clear_stats();
    for (int i = 0; i < 256; i++) run_frame(16'h1000, 16'h7800, 3, 1'b0);
    wait_idle();
    n_checks++;
    if (sum_y[0] != 512) begin n_fail++; $display("FAIL ch0_mean: sum %0d expected 512", sum_y[0]); end
    n_checks++;
    if (sum_y[1] != 3840) begin n_fail++; $display("FAIL ch1_mean: sum %0d expected 3840", sum_y[1]); end
    s0 = sum_y[0];
    do_reset();
    clear_stats();
    for (int i = 0; i < 256; i++) run_frame(16'h1000, 16'h0000, 3, 1'b0);
    wait_idle();
    n_checks++;
    if (sum_y[0] != s0) begin n_fail++; $display("FAIL ch_independence: ch0 sum %0d expected %0d", sum_y[0], s0); end
  endtask

  task automatic test_full_scale();
    do_reset();
    clear_stats();
    for (int i = 0; i < 64; i++) run_frame(16'hFFFF, 16'hFFFF, 2, 1'b0);
    wait_idle();
    n_checks++;
    if (min_y < 16) begin n_fail++; $display("FAIL full_scale_wrap: min y %0d expected >= 16", min_y); end
  endtask

  task automatic test_back_to_back();
    run_frame(16'h0400, 16'hF000, 0, 1'b0);
    run_frame(16'h2C00, 16'h0123, 3, 1'b1);
    run_frame(16'h7FFF, 16'h0000, 2, 1'b0);
    run_frame(16'h0001, 16'hABCD, 1, 1'b1);
    run_frame(16'h3A55, 16'h1C00, 3, 1'b0);
    wait_idle();
  endtask

  task automatic test_overrun();
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_initial: got %b expected 0", overrun); end
    run_frame(16'h2C00, 16'h1234, 1, 1'b0);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    wait_idle();
    repeat (3) @(negedge clk);
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    run_frame(16'h2C00, 16'h2C00, 3, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL midreset_overrun: got %b expected 0", overrun); end
    reset = 1'b0;
    sb.delete();
    lfsr_m = '1;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 3; k++) hist_m[c][k] = 0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (y_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL midreset_no_output: %0d y_valid cycles, expected 0", seen); end
  endtask

  task automatic test_dither();
    do_reset();
    clear_stats();
    for (int i = 0; i < 4096; i++) run_frame(16'h2C00, 16'h2C00, 2, 1'b1);
    wait_idle();
    n_checks++;
    if (sum_y[0] * 100 < 4096 * 545 || sum_y[0] * 100 > 4096 * 555) begin
      n_fail++;
      $display("FAIL dither_mean: sum %0d over 4096 frames, expected 22324..22732", sum_y[0]);
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    u = '0;
    order = '0;
    dither_en = 1'b0;
    clear_stats();
    repeat (3) @(negedge clk);
    test_reset();
    test_order0();
    test_order1();
    test_two_channel();
    test_full_scale();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    test_dither();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
